mul_result_fifo: RTL and testbench

MUL_RESULT_FIFO -- requirements
Module: mul_result_fifo

---
 rtl/mul_result_pkg.sv | 32 +++
 rtl/bus_strobe_sync.sv | 34 +++
 rtl/mul_result_fifo.sv | 164 ++++++++++++++++
 tb/tb_mul_result_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_pkg.sv
// Shared definitions for the multiplier result FIFO: register map offsets,
// CTRL/STATUS bit positions and the stored entry layout.
package mul_result_pkg;

    localparam logic [15:0] OFF_HEAD_W = 16'h0000;
    localparam logic [15:0] OFF_HEAD_L = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h0010;
    localparam logic [15:0] OFF_CTRL   = 16'h0018;

    localparam int CTRL_POP    = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_EMPTY   = 8;
    localparam int ST_FULL    = 9;
    localparam int ST_DROP    = 10;
    localparam int ST_CNT_LSB = 16;

    localparam int HL_OVF = 8;

    typedef struct packed {
        logic        ovf;
        logic [5:0]  l;
        logic [31:0] w;
    } res_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_strobe_sync.sv
// Brings an asynchronous bus strobe into clk: 2-flop synchroniser plus a
// one-cycle pulse on each synchronised rising edge.
module bus_strobe_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic strobe_i,
    output logic pulse_o
);

    logic       s1_q, s2_q, s3_q;
    logic [1:0] fill_q;
    logic       arm_q;

    // The edge detector only arms once the synchronised strobe has been seen
    // low after reset, so a strobe already high at release is not an edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            fill_q <= 2'b00;
            arm_q  <= 1'b0;
        end else begin
            s1_q   <= strobe_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fill_q <= {fill_q[0], 1'b1};
            arm_q  <= arm_q | (fill_q[1] & ~s2_q);
        end
    end

    assign pulse_o = s2_q & ~s3_q & arm_q;

endmodule

// File: rtl/mul_result_fifo.sv
// Result FIFO between the multiplier and a slow asynchronous register bus:
// flop storage, drop accounting, CTRL-driven pop/flush/clear and an interrupt.
module mul_result_fifo
    import mul_result_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [15:0] BASE  = 16'h03C0
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [31:0]              res_w,
    input  logic [5:0]               res_l,
    input  logic                     res_ovf,
    input  logic [15:0]              saddress,
    input  logic                     srd,
    input  logic                     swr,
    input  logic [31:0]              sdata_in,
    output logic [31:0]              sdata_out,
    output logic                     irq,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [15:0] A_HEAD_W = BASE + OFF_HEAD_W;
    localparam logic [15:0] A_HEAD_L = BASE + OFF_HEAD_L;
    localparam logic [15:0] A_STATUS = BASE + OFF_STATUS;
    localparam logic [15:0] A_CTRL   = BASE + OFF_CTRL;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    dcnt_q, dcnt_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic [31:0]   sdo_q, sdo_d;
    logic [31:0]   rdata;

    res_entry_t    mem_q [DEPTH];
    res_entry_t    head, wr_entry;

    logic rd_pulse, wr_pulse;
    logic full, empty, ctrl_wr;
    logic do_flush, do_clr, do_pop, do_push, do_drop;

    bus_strobe_sync u_srd_sync (
        .clk      (clk),
        .n_reset  (n_reset),
        .strobe_i (srd),
        .pulse_o  (rd_pulse)
    );

    bus_strobe_sync u_swr_sync (
        .clk      (clk),
        .n_reset  (n_reset),
        .strobe_i (swr),
        .pulse_o  (wr_pulse)
    );

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign res_ready = ~full;

    assign ctrl_wr  = wr_pulse && (saddress == A_CTRL);
    assign do_flush = ctrl_wr & sdata_in[CTRL_FLUSH];
    assign do_clr   = ctrl_wr & sdata_in[CTRL_CLR];
    assign do_pop   = ctrl_wr & sdata_in[CTRL_POP] & ~empty;
    // A push that coincides with a flush vanishes; it is neither stored nor a drop.
    assign do_push  = res_valid & ~full & ~do_flush;
    assign do_drop  = res_valid &  full & ~do_flush;

    assign wr_entry = '{ovf: res_ovf, l: res_l, w: res_w};
    assign head     = mem_q[rptr_q];

    logic unused_ok;
    assign unused_ok = ^sdata_in[31:4];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset)
                    mem_q[gi] <= '0;
                else if (do_push && (wptr_q == PW'(gi)))
                    mem_q[gi] <= wr_entry;
            end
        end
    endgenerate

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        dcnt_d   = dcnt_q;
        if (do_clr) begin
            sticky_d = 1'b0;
            dcnt_d   = '0;
        end else if (do_drop) begin
            sticky_d = 1'b1;
            dcnt_d   = sat_inc8(dcnt_q);
        end
        irq_en_d = ctrl_wr ? sdata_in[CTRL_IRQ_EN] : irq_en_q;
        irq_d    = irq_en_q & ~empty;
    end

    always_comb begin
        rdata = '0;
        case (saddress)
            A_HEAD_W: rdata = empty ? 32'h0 : head.w;
            A_HEAD_L: rdata = empty ? 32'h0 : {23'h0, head.ovf, 2'b00, head.l};
            A_STATUS: rdata = {8'h00, dcnt_q, 5'h00, sticky_q, full, empty, 3'b000, 5'(level_q)};
            A_CTRL:   rdata = {28'h0, irq_en_q, 3'b000};
            default:  rdata = '0;
        endcase
        sdo_d = rd_pulse ? rdata : sdo_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            sticky_q <= 1'b0;
            dcnt_q   <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            sdo_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            dcnt_q   <= dcnt_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            sdo_q    <= sdo_d;
        end
    end

    assign sdata_out = sdo_q;
    assign irq       = irq_q;
    assign level     = level_q;

endmodule

// File: tb/tb_mul_result_fifo.sv
// Randomised bench for mul_result_fifo against a queue-based model of the FIFO
// and its register window.
module tb_mul_result_fifo;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h03C0;
    localparam logic [15:0] A_HW  = BASE + 16'h00;
    localparam logic [15:0] A_HL  = BASE + 16'h08;
    localparam logic [15:0] A_ST  = BASE + 16'h10;
    localparam logic [15:0] A_CT  = BASE + 16'h18;

    logic        clk = 1'b0, n_reset = 1'b0;
    logic        res_valid = 1'b0, res_ready;
    logic [31:0] res_w = '0;
    logic [5:0]  res_l = '0;
    logic        res_ovf = 1'b0;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0, swr = 1'b0;
    logic [31:0] sdata_in = '0, sdata_out;
    logic        irq;
    logic [2:0]  level;

    mul_result_fifo #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .n_reset(n_reset), .res_valid(res_valid), .res_ready(res_ready),
        .res_w(res_w), .res_l(res_l), .res_ovf(res_ovf), .saddress(saddress),
        .srd(srd), .swr(swr), .sdata_in(sdata_in), .sdata_out(sdata_out),
        .irq(irq), .level(level)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    logic [38:0] mq[$];
    bit          m_sticky = 0, m_irq_en = 0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clock of the FIFO rules: optional CTRL write and optional upstream result.
    task automatic model_cycle(input bit is_ctrl, input logic [31:0] d, input bit pv, input logic [38:0] e);
        bit full_b;
        full_b = (mq.size() == DEPTH);
        if (is_ctrl) m_irq_en = d[3];
        if (is_ctrl && d[1]) begin
            mq.delete();
        end else begin
            if (is_ctrl && d[0] && mq.size() > 0) void'(mq.pop_front());
            if (pv) begin
                if (!full_b) mq.push_back(e);
                else begin
                    m_sticky = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        if (is_ctrl && d[2]) begin
            m_sticky = 0;
            m_cnt    = 0;
        end
    endtask

    function automatic logic [31:0] exp_reg(input logic [15:0] a);
        int n;
        n = mq.size();
        if (a == A_HW) return (n > 0) ? {1'b0, mq[0][31:0]} : 32'h0;
        if (a == A_HL) return (n > 0) ? 32'(mq[0][38]) * 256 + 32'(mq[0][37:32]) : 32'h0;
        if (a == A_ST) return 32'(n) + ((n == 0) ? 32'h100 : 0) + ((n == DEPTH) ? 32'h200 : 0)
                              + (m_sticky ? 32'h400 : 0) + 32'(m_cnt) * 65536;
        if (a == A_CT) return m_irq_en ? 32'h8 : 32'h0;
        return 32'h0;
    endfunction

    task automatic push(input logic [31:0] w, input logic [5:0] l, input bit ovf);
        res_valid = 1'b1; res_w = w; res_l = l; res_ovf = ovf;
        step(1);
        res_valid = 1'b0;
        model_cycle(0, '0, 1, {ovf, l, w});
    endtask

    task automatic push_rand();
        push($urandom, 6'($urandom_range(0, 32)), 1'($urandom));
    endtask

    // Bus write held 10 clk; optionally lands an upstream result in the write cycle.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input bit pv,
                             input logic [31:0] w, input logic [5:0] l, input bit ovf);
        bit seen;
        seen = 0;
        saddress = a; sdata_in = d; swr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            res_valid = 1'b0;
            if (!seen && dut.u_swr_sync.pulse_o) begin
                seen = 1;
                res_valid = pv; res_w = w; res_l = l; res_ovf = ovf;
            end
        end
        swr = 1'b0;
        step(3);
        chk("wr_pulse_seen", 32'(seen), 32'h1);
        model_cycle(a == A_CT, d, pv, {ovf, l, w});
    endtask

    task automatic ctrl(input logic [31:0] d);
        bus_write(A_CT, d, 0, '0, '0, 0);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        saddress = a; srd = 1'b1;
        step(10);
        srd = 1'b0;
        step(3);
        d = sdata_out;
    endtask

    task automatic check_read(input string tag, input logic [15:0] a);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp_reg(a));
    endtask

    task automatic check_pins(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".ready"}, 32'(res_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".irq"},   32'(irq), 32'(m_irq_en && mq.size() > 0));
    endtask

    task automatic check_all(input string tag);
        check_read({tag, ".hw"}, A_HW);
        check_read({tag, ".hl"}, A_HL);
        check_read({tag, ".st"}, A_ST);
        check_read({tag, ".ct"}, A_CT);
        check_pins(tag);
    endtask

    initial begin
        logic [31:0] d, d0;
        // Reset with a CTRL write strobe already high at release.
        saddress = A_CT; sdata_in = 32'h8; swr = 1'b1;
        step(3);
        chk("rst.sdo", sdata_out, 32'h0);
        chk("rst.level", 32'(level), 32'h0);
        chk("rst.ready", 32'(res_ready), 32'h1);
        chk("rst.irq", 32'(irq), 32'h0);
        n_reset = 1'b1;
        step(10);
        swr = 1'b0;
        step(3);
        check_read("rst_strobe.ctrl", A_CT);
        check_pins("rst_strobe");

        push(32'h0000_1234, 6'd5, 0);
        bus_read(A_HW, d); chk("basic.hw", d, 32'h0000_1234);
        bus_read(A_HL, d); chk("basic.hl", d, 32'h0000_0005);
        bus_read(A_ST, d); chk("basic.st", d, 32'h0000_0001);

        // Overfill: 5 pushes into 4 entries.
        ctrl(32'h2);
        for (int i = 0; i < 5; i++) push(32'hA000_0000 + 32'(i), 6'(i), 1'(i & 1));
        chk("over.ready", 32'(res_ready), 32'h0);
        bus_read(A_ST, d); chk("over.st", d, 32'h0001_0604);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_HW, d); chk("over.order", d, 32'hA000_0000 + 32'(i));
            ctrl(32'h1);
        end
        check_all("drained");

        // Level 2 with pop+push in the same cycle, wrapping the pointers.
        for (int i = 0; i < 3; i++) push(32'hB000_0000 + 32'(i), 6'd1, 0);
        ctrl(32'h1);
        for (int i = 3; i < 6; i++) begin
            bus_write(A_CT, 32'h1, 1, 32'hB000_0000 + 32'(i), 6'd2, 1);
            chk("pp.level", 32'(level), 32'h2);
        end
        for (int i = 4; i < 6; i++) begin
            bus_read(A_HW, d); chk("pp.order", d, 32'hB000_0000 + 32'(i));
            ctrl(32'h1);
        end
        check_all("pp.end");

        // Interrupt timing.
        ctrl(32'h8);
        chk("irq.empty", 32'(irq), 32'h0);
        res_valid = 1'b1; res_w = 32'h77; res_l = 6'd6; res_ovf = 0;
        @(posedge clk); #1;
        res_valid = 1'b0;
        model_cycle(0, '0, 1, {1'b0, 6'd6, 32'h77});
        chk("irq.same_clk", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("irq.next_clk", 32'(irq), 32'h1);
        ctrl(32'hA);
        chk("irq.flush", 32'(irq), 32'h0);
        chk("irq.flush_level", 32'(level), 32'h0);

        // Flush with a push in the same cycle; neither stored nor dropped.
        for (int i = 0; i < DEPTH; i++) push_rand();
        bus_write(A_CT, 32'h2, 1, 32'hDEAD, 6'd3, 0);
        check_all("flush_push");

        // Drop counter saturation, then clear racing a drop.
        for (int i = 0; i < DEPTH + 260; i++) push_rand();
        bus_read(A_ST, d); chk("sat.st", d, 32'h00FF_0604);
        bus_write(A_CT, 32'h4, 1, 32'h1, 6'd1, 0);
        bus_read(A_ST, d); chk("clr_drop.st", d, 32'h0000_0204);
        ctrl(32'h2);

        // Randomised traffic.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: push_rand();
                3: ctrl(32'h1 | (m_irq_en ? 32'h8 : 32'h0));
                4: bus_write(A_CT, 32'($urandom_range(0, 15)) & ((($urandom & 3) != 0) ? 32'hD : 32'hF),
                             1'($urandom), $urandom, 6'($urandom_range(0, 32)), 1'($urandom));
                5: check_all("rnd");
                6: bus_write(A_HW, $urandom, 0, '0, '0, 0);
                default: check_read("rnd.unmapped", BASE + 16'h04);
            endcase
            step(1);
            check_pins("rnd.pins");
        end

        // Reset mid-operation.
        ctrl(32'h2);
        for (int i = 0; i < 3; i++) push_rand();
        bus_read(A_ST, d0); chk("mid.st_pre", d0, exp_reg(A_ST));
        n_reset = 1'b0; #1;
        mq.delete(); m_sticky = 0; m_cnt = 0; m_irq_en = 0;
        chk("mid.sdo", sdata_out, 32'h0);
        chk("mid.level", 32'(level), 32'h0);
        chk("mid.ready", 32'(res_ready), 32'h1);
        step(2);
        n_reset = 1'b1;
        step(4);
        push(32'hCAFE_F00D, 6'd24, 1);
        bus_read(A_HW, d); chk("mid.hw", d, 32'hCAFE_F00D);
        check_read("mid.hl", A_HL);

        // Long strobes: one pop per held write, read has no side effect.
        push(32'h5, 6'd2, 0);
        bus_read(A_HW, d); chk("long.rd", d, 32'hCAFE_F00D);
        chk("long.rd_level", 32'(level), 32'h2);
        ctrl(32'h1);
        chk("long.wr_level", 32'(level), 32'h1);
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
